logicnet_lut_layer: RTL and testbench
=====================================

LOGICNET_LUT_LAYER -- requirements
Module: logicnet_lut_layer

Interface
REQ-001 SHALL provide parameter NEURONS, default 8: neurons in the layer.
REQ-002 SHALL provide parameter FAN_IN, default 4: input bits per neuron (table depth 2^FAN_IN).
REQ-003 SHALL provide parameter OUT_BITS, default 2: output bits per neuron.
REQ-004 SHALL provide parameter IN_WIDTH, default 32: layer input bus width.
REQ-005 SHALL provide parameter CONN, flat NEURONS*FAN_IN indices of clog2(IN_WIDTH) bits: input bus bit feeding each neuron input; index 0 is the neuron LSB.
REQ-006 SHALL provide parameter INIT_TABLE, flat NEURONS*2^FAN_IN*OUT_BITS bits: reset/default truth tables, neuron-major, address-minor.
REQ-007 SHALL have one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-008 s_valid input 1: input sample valid.
REQ-009 s_ready output 1: block accepts sample.
REQ-010 s_data input IN_WIDTH: input sample.
REQ-011 m_valid output 1: result valid.
REQ-012 m_ready input 1: downstream accepts result.
REQ-013 m_data output NEURONS*OUT_BITS: concatenated neuron outputs, neuron 0 at LSBs.
REQ-014 tbl_wr_en input 1; tbl_wr_neuron input clog2(NEURONS); tbl_wr_addr input FAN_IN; tbl_wr_data input OUT_BITS: table write port.

Function
REQ-015 Transfer SHALL occur on s_valid&&s_ready (input) and m_valid&&m_ready (output).
REQ-016 Pipeline SHALL be two registered stages: S1 captures the gathered FAN_IN-bit address per neuron via CONN; S2 captures the table lookup into m_data.
REQ-017 Latency SHALL be 2 cycles from input transfer to m_valid, absent backpressure; throughput one sample per cycle.
REQ-018 Each stage SHALL advance when its successor is empty or advancing; s_ready = !S1_valid || S2 advancing, where S2 advances = !m_valid || m_ready.
REQ-019 m_data and m_valid SHALL hold stable while m_valid && !m_ready.
REQ-020 Sample order SHALL be preserved; no sample dropped or duplicated under any valid/ready pattern.
REQ-021 A table write SHALL take effect at the next clock edge; a lookup in the same cycle as a write to its entry SHALL return the old value.
REQ-022 Writes SHALL be accepted regardless of pipeline state; tbl_wr_neuron >= NEURONS SHALL be ignored.
REQ-023 Combinational path from m_ready to s_ready SHALL be the only ready path; no path from s_valid to s_ready.

Reset
REQ-024 On rst: S1_valid=0, m_valid=0, m_data=0, s_ready=1 the cycle after reset deasserts.
REQ-025 On rst: all tables SHALL reload INIT_TABLE; in-flight samples discarded.
REQ-026 rst SHALL take priority over a concurrent tbl_wr_en and input transfer.

Configuration
REQ-027 Macro LOGICNET_LUT_WR_EN defined: tables are registers, writable per REQ-021/022.
REQ-028 Macro undefined: tables are constant from INIT_TABLE (distributed ROM); tbl_wr_* ports remain but SHALL be ignored.

Structure
REQ-029 Package logicnet_pkg SHALL hold the clog2 helper, the table-index function (neuron, addr -> bit offset), and default parameter constants.
REQ-030 One sub-module logicnet_neuron_lut SHALL implement a single neuron table plus write port; logicnet_lut_layer instantiates NEURONS copies.

Verification
REQ-031 Defaults, neuron 0 table out={2{addr[3]}}, CONN0={0,1,2,3}: s_data=0x8 then 0x7 back-to-back, m_ready=1 -> m_data[1:0]=2'b11 at cycle 2, 2'b00 at cycle 3.
REQ-032 Backpressure: 4 samples streamed, m_ready low 3 cycles mid-stream -> s_ready low after S1/S2 fill; all 4 results in order, m_data stable while stalled.
REQ-033 With LOGICNET_LUT_WR_EN: write neuron 2 addr 0x5 data 2'b01 then input routing 0x5 to neuron 2 -> m_data[5:4]=2'b01; same-cycle write/lookup returns old value.
REQ-034 Without LOGICNET_LUT_WR_EN: identical write -> m_data[5:4] keeps INIT_TABLE value.
REQ-035 rst asserted with 2 samples in flight and a pending write -> m_valid=0, m_data=0 next cycle; tables equal INIT_TABLE.
REQ-036 Random valid/ready (10k samples, random tables) -> scoreboard match vs reference model, zero drops.

Source files
------------

// File: rtl/logicnet_pkg.sv
// Shared helpers and default configuration for the LogicNet LUT layer.
// Default CONN wires neuron n input k to bus bit n*FAN_IN+k.
package logicnet_pkg;

    localparam int DEF_NEURONS  = 8;
    localparam int DEF_FAN_IN   = 4;
    localparam int DEF_OUT_BITS = 2;
    localparam int DEF_IN_WIDTH = 32;

    // Never returns less than 1 so index ports stay legal for degenerate sizes.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int tbl_index(input int neuron, input int addr,
                                     input int fan_in, input int out_bits);
        return (neuron * (1 << fan_in) + addr) * out_bits;
    endfunction

    localparam int DEF_CONN_W = clog2(DEF_IN_WIDTH);
    localparam int DEF_CONN_BITS = DEF_NEURONS * DEF_FAN_IN * DEF_CONN_W;
    localparam int DEF_TBL_BITS = DEF_NEURONS * (1 << DEF_FAN_IN) * DEF_OUT_BITS;

    function automatic logic [DEF_CONN_BITS-1:0] def_conn();
        logic [DEF_CONN_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < DEF_NEURONS * DEF_FAN_IN; i++) begin
            r[i*DEF_CONN_W +: DEF_CONN_W] = i[DEF_CONN_W-1:0];
        end
        return r;
    endfunction

    // Every output bit follows the address MSB, inverted by the low neuron-index bits.
    function automatic logic [DEF_TBL_BITS-1:0] def_init();
        logic [DEF_TBL_BITS-1:0] r;
        r = '0;
        for (int n = 0; n < DEF_NEURONS; n++) begin
            for (int a = 0; a < (1 << DEF_FAN_IN); a++) begin
                r[tbl_index(n, a, DEF_FAN_IN, DEF_OUT_BITS) +: DEF_OUT_BITS] =
                    {DEF_OUT_BITS{a[DEF_FAN_IN-1]}} ^ n[DEF_OUT_BITS-1:0];
            end
        end
        return r;
    endfunction

    localparam logic [DEF_CONN_BITS-1:0] DEF_CONN = def_conn();
    localparam logic [DEF_TBL_BITS-1:0] DEF_INIT_TABLE = def_init();

endpackage

// File: rtl/logicnet_neuron_lut.sv
// One neuron truth table. With LOGICNET_LUT_WR_EN the table is a writable register
// reloaded from INIT on reset; otherwise it is a constant ROM and the write port is unused.
module logicnet_neuron_lut
    import logicnet_pkg::*;
#(
    parameter int FAN_IN   = DEF_FAN_IN,
    parameter int OUT_BITS = DEF_OUT_BITS,
    parameter logic [(2**FAN_IN)*OUT_BITS-1:0] INIT = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [FAN_IN-1:0]   wr_addr,
    input  logic [OUT_BITS-1:0] wr_data,
    input  logic [FAN_IN-1:0]   rd_addr,
    output logic [OUT_BITS-1:0] rd_data
);

    localparam int TW = (2**FAN_IN) * OUT_BITS;

`ifdef LOGICNET_LUT_WR_EN
    logic [TW-1:0] table_d, table_q;

    always_comb begin
        table_d = table_q;
        if (wr_en) table_d[int'(wr_addr)*OUT_BITS +: OUT_BITS] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) table_q <= INIT;
        else     table_q <= table_d;
    end

    // Reads see the pre-write contents in the cycle a write is presented.
    always_comb rd_data = table_q[int'(rd_addr)*OUT_BITS +: OUT_BITS];
`else
    logic unused_wr_port;
    assign unused_wr_port = ^{clk, rst, wr_en, wr_addr, wr_data};

    always_comb rd_data = INIT[int'(rd_addr)*OUT_BITS +: OUT_BITS];
`endif

endmodule

// File: rtl/logicnet_lut_layer.sv
// LogicNet LUT layer: gather per-neuron addresses (stage 1), table lookup (stage 2).
// Define LOGICNET_LUT_WR_EN to make the neuron tables writable at runtime.
module logicnet_lut_layer
    import logicnet_pkg::*;
#(
    parameter int NEURONS  = DEF_NEURONS,
    parameter int FAN_IN   = DEF_FAN_IN,
    parameter int OUT_BITS = DEF_OUT_BITS,
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter logic [NEURONS*FAN_IN*clog2(IN_WIDTH)-1:0] CONN = DEF_CONN,
    parameter logic [NEURONS*(2**FAN_IN)*OUT_BITS-1:0] INIT_TABLE = DEF_INIT_TABLE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [IN_WIDTH-1:0]          s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [NEURONS*OUT_BITS-1:0]  m_data,
    input  logic                         tbl_wr_en,
    input  logic [clog2(NEURONS)-1:0]    tbl_wr_neuron,
    input  logic [FAN_IN-1:0]            tbl_wr_addr,
    input  logic [OUT_BITS-1:0]          tbl_wr_data
);

    localparam int CW = clog2(IN_WIDTH);
    localparam int TW = (2**FAN_IN) * OUT_BITS;

    logic [NEURONS*FAN_IN-1:0]   gathered;
    logic [NEURONS*FAN_IN-1:0]   addr_p1_d, addr_p1_q;
    logic                        vld_p1_d, vld_p1_q;
    logic [NEURONS*OUT_BITS-1:0] lut_out;
    logic [NEURONS*OUT_BITS-1:0] m_data_d, m_data_q;
    logic                        m_valid_d, m_valid_q;
    logic                        s2_adv, s1_adv;

    always_comb begin
        gathered = '0;
        for (int i = 0; i < NEURONS * FAN_IN; i++) begin
            gathered[i] = s_data[CONN[i*CW +: CW]];
        end
    end

    for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
        logic wr_sel;
        // Neuron indices beyond NEURONS never match, so such writes fall away.
        assign wr_sel = tbl_wr_en && (int'(tbl_wr_neuron) == n);

        logicnet_neuron_lut #(
            .FAN_IN   (FAN_IN),
            .OUT_BITS (OUT_BITS),
            .INIT     (INIT_TABLE[n*TW +: TW])
        ) u_lut (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_sel),
            .wr_addr (tbl_wr_addr),
            .wr_data (tbl_wr_data),
            .rd_addr (addr_p1_q[n*FAN_IN +: FAN_IN]),
            .rd_data (lut_out[n*OUT_BITS +: OUT_BITS])
        );
    end

    always_comb begin
        s2_adv    = !m_valid_q || m_ready;
        s1_adv    = !vld_p1_q || s2_adv;

        vld_p1_d  = vld_p1_q;
        addr_p1_d = addr_p1_q;
        if (s1_adv) begin
            vld_p1_d = s_valid;
            if (s_valid) addr_p1_d = gathered;
        end

        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (s2_adv) begin
            m_valid_d = vld_p1_q;
            if (vld_p1_q) m_data_d = lut_out;
        end
    end

    // Stage 1: gathered addresses
    always_ff @(posedge clk) begin
        if (rst) vld_p1_q <= 1'b0;
        else     vld_p1_q <= vld_p1_d;
    end

    always_ff @(posedge clk) begin
        addr_p1_q <= addr_p1_d;
    end

    // Stage 2: table outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign s_ready = s1_adv;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_logicnet_lut_layer.sv
// Scoreboard bench for logicnet_lut_layer with its own CONN/INIT_TABLE; follows
// LOGICNET_LUT_WR_EN for the expected effect of table writes.
`timescale 1ns/1ps
module tb_logicnet_lut_layer;

    localparam int NEURONS  = 8;
    localparam int FAN_IN   = 4;
    localparam int OUT_BITS = 2;
    localparam int IN_WIDTH = 32;
    localparam int CW       = 5;
    localparam int DEPTH    = 16;

    function automatic int conn_of(int n, int k);
        int i;
        i = n * FAN_IN + k;
        if (n == 0) return k;
        return (i * 7 + 3) % IN_WIDTH;
    endfunction

    function automatic logic [1:0] init_of(int n, int a);
        int v;
        if (n == 0) return {a[3], a[3]};
        v = n * 37 + a * 11 + (a >> 1) * 5 + ((a * a) >> 1);
        return v[1:0];
    endfunction

    function automatic logic [NEURONS*FAN_IN*CW-1:0] build_conn();
        logic [NEURONS*FAN_IN*CW-1:0] r;
        int c;
        r = '0;
        for (int n = 0; n < NEURONS; n++)
            for (int k = 0; k < FAN_IN; k++) begin
                c = conn_of(n, k);
                r[(n*FAN_IN+k)*CW +: CW] = c[CW-1:0];
            end
        return r;
    endfunction

    function automatic logic [NEURONS*DEPTH*OUT_BITS-1:0] build_init();
        logic [NEURONS*DEPTH*OUT_BITS-1:0] r;
        r = '0;
        for (int n = 0; n < NEURONS; n++)
            for (int a = 0; a < DEPTH; a++)
                r[(n*DEPTH+a)*OUT_BITS +: OUT_BITS] = init_of(n, a);
        return r;
    endfunction

    localparam logic [NEURONS*FAN_IN*CW-1:0]        TB_CONN = build_conn();
    localparam logic [NEURONS*DEPTH*OUT_BITS-1:0]   TB_INIT = build_init();

`ifdef LOGICNET_LUT_WR_EN
    localparam logic [1:0] EXP_W1 = 2'b01;
    localparam logic [1:0] EXP_W2 = 2'b10;
`else
    localparam logic [1:0] EXP_W1 = init_of(2, 5);
    localparam logic [1:0] EXP_W2 = init_of(2, 5);
`endif

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic                         s_valid = 1'b0;
    logic                         s_ready;
    logic [IN_WIDTH-1:0]          s_data = '0;
    logic                         m_valid;
    logic                         m_ready = 1'b0;
    logic [NEURONS*OUT_BITS-1:0]  m_data;
    logic                         tbl_wr_en = 1'b0;
    logic [2:0]                   tbl_wr_neuron = '0;
    logic [FAN_IN-1:0]            tbl_wr_addr = '0;
    logic [OUT_BITS-1:0]          tbl_wr_data = '0;

    always #5 clk = ~clk;

    logicnet_lut_layer #(
        .NEURONS    (NEURONS),
        .FAN_IN     (FAN_IN),
        .OUT_BITS   (OUT_BITS),
        .IN_WIDTH   (IN_WIDTH),
        .CONN       (TB_CONN),
        .INIT_TABLE (TB_INIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .tbl_wr_en     (tbl_wr_en),
        .tbl_wr_neuron (tbl_wr_neuron),
        .tbl_wr_addr   (tbl_wr_addr),
        .tbl_wr_data   (tbl_wr_data)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_in  = 0;
    int n_out = 0;
    logic [NEURONS*OUT_BITS-1:0] exp_q[$];
    logic [NEURONS*OUT_BITS-1:0] last_out = '0;
    logic [1:0] mtbl [NEURONS][DEPTH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reload_model();
        for (int n = 0; n < NEURONS; n++)
            for (int a = 0; a < DEPTH; a++)
                mtbl[n][a] = init_of(n, a);
    endtask

    function automatic logic [NEURONS*OUT_BITS-1:0] model_out(logic [IN_WIDTH-1:0] d);
        logic [NEURONS*OUT_BITS-1:0] r;
        logic [FAN_IN-1:0] a;
        r = '0;
        for (int n = 0; n < NEURONS; n++) begin
            for (int k = 0; k < FAN_IN; k++) a[k] = d[conn_of(n, k)];
            r[n*OUT_BITS +: OUT_BITS] = mtbl[n][a];
        end
        return r;
    endfunction

    function automatic logic [IN_WIDTH-1:0] make_data(int n, int a);
        logic [IN_WIDTH-1:0] d;
        d = '0;
        for (int k = 0; k < FAN_IN; k++)
            if (a[k]) d[conn_of(n, k)] = 1'b1;
        return d;
    endfunction

    // Transfers are observed mid-cycle; they complete at the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            reload_model();
        end else begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_output", 64'(exp_q.size()), 64'd1);
                end else begin
                    chk("sb_data", 64'(m_data), 64'(exp_q.pop_front()));
                    last_out = m_data;
                    n_out++;
                end
            end
`ifdef LOGICNET_LUT_WR_EN
            if (tbl_wr_en && int'(tbl_wr_neuron) < NEURONS)
                mtbl[tbl_wr_neuron][tbl_wr_addr] = tbl_wr_data;
`endif
            if (s_valid && s_ready) begin
                exp_q.push_back(model_out(s_data));
                n_in++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [IN_WIDTH-1:0] d);
        int waited;
        s_valid = 1'b1;
        s_data  = d;
        waited  = 0;
        @(negedge clk);
        while (!s_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) chk("push_timeout", 64'(s_ready), 64'd1);
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        m_ready = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || m_valid); i++) @(negedge clk);
        chk(tag, 64'(exp_q.size()), 64'd0);
        cyc();
    endtask

    task automatic write_tbl(input int n, input int a, input logic [1:0] v);
        tbl_wr_en     = 1'b1;
        tbl_wr_neuron = n[2:0];
        tbl_wr_addr   = a[FAN_IN-1:0];
        tbl_wr_data   = v;
        cyc();
        tbl_wr_en     = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [IN_WIDTH-1:0] d [4];
        logic [NEURONS*OUT_BITS-1:0] held;
        int base, cycles;

        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        cyc();

        // Two back-to-back samples, two-cycle latency
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h8;
        cyc();
        s_data  = 32'h7;
        cyc();
        s_valid = 1'b0;
        @(negedge clk);
        chk("lat_c2_valid", 64'(m_valid), 64'd1);
        chk("lat_c2_data", 64'(m_data[1:0]), 64'(2'b11));
        cyc();
        @(negedge clk);
        chk("lat_c3_valid", 64'(m_valid), 64'd1);
        chk("lat_c3_data", 64'(m_data[1:0]), 64'(2'b00));
        cyc();
        @(negedge clk);
        chk("lat_c4_idle", 64'(m_valid), 64'd0);
        drain("drain_latency");

        // Backpressure: three stall cycles mid-stream
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        base = n_out;
        s_valid = 1'b1;
        s_data  = d[0];
        cyc();
        s_data  = d[1];
        cyc();
        held    = m_data;
        m_ready = 1'b0;
        s_data  = d[2];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_s_ready_low", 64'(s_ready), 64'd0);
            chk("bp_hold_valid", 64'(m_valid), 64'd1);
            chk("bp_hold_data", 64'(m_data), 64'(held));
            cyc();
        end
        m_ready = 1'b1;
        push_sample(d[2]);
        push_sample(d[3]);
        drain("drain_backpressure");
        chk("bp_count", 64'(n_out - base), 64'd4);

        // Table write, then same-cycle write/lookup
        write_tbl(2, 5, 2'b01);
        push_sample(make_data(2, 5));
        drain("drain_wr1");
        chk("wr_new_value", 64'(last_out[5:4]), 64'(EXP_W1));
        s_valid = 1'b1;
        s_data  = make_data(2, 5);
        cyc();
        s_valid = 1'b0;
        write_tbl(2, 5, 2'b10);
        drain("drain_wr2");
        chk("wr_same_cycle_old", 64'(last_out[5:4]), 64'(EXP_W1));
        push_sample(make_data(2, 5));
        drain("drain_wr3");
        chk("wr_after_same_cycle", 64'(last_out[5:4]), 64'(EXP_W2));

        // Reset with two samples in flight, a pending write and an offered sample
        m_ready = 1'b0;
        push_sample($urandom);
        push_sample($urandom);
        rst           = 1'b1;
        tbl_wr_en     = 1'b1;
        tbl_wr_neuron = 3'd2;
        tbl_wr_addr   = 4'h5;
        tbl_wr_data   = 2'b00;
        s_valid       = 1'b1;
        s_data        = make_data(2, 5);
        cyc();
        rst       = 1'b0;
        tbl_wr_en = 1'b0;
        s_valid   = 1'b0;
        @(negedge clk);
        chk("rst2_m_valid", 64'(m_valid), 64'd0);
        chk("rst2_m_data", 64'(m_data), 64'd0);
        chk("rst2_s_ready", 64'(s_ready), 64'd1);
        cyc();
        m_ready = 1'b1;
        base = n_out;
        push_sample(make_data(2, 5));
        drain("drain_rst2");
        chk("rst2_tbl_reloaded", 64'(last_out[5:4]), 64'(init_of(2, 5)));
        chk("rst2_no_stale", 64'(n_out - base), 64'd1);

        // Random valid/ready traffic
        base = n_in;
        cycles = 0;
        begin
            int out_base;
            out_base = n_out;
            while (n_in - base < 10000 && cycles < 60000) begin
                s_valid = ($urandom_range(0, 9) < 7);
                s_data  = $urandom;
                m_ready = ($urandom_range(0, 9) < 7);
                cyc();
                cycles++;
            end
            s_valid = 1'b0;
            chk("rand_inputs", 64'(n_in - base), 64'd10000);
            drain("drain_random");
            chk("rand_outputs", 64'(n_out - out_base), 64'd10000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
